// File: rtl/coef_run_expander_pkg.sv
// Shared types and constants for the coefficient run expander.
// Decode-side symbol bundle plus run/block limits.
package coef_run_expander_pkg;

   localparam int DW     = 10;
   localparam int VLI_W  = DW - 1;
   localparam int SIZE_W = $clog2(VLI_W) + 1;

   localparam logic [3:0] ZRL_RUN  = 4'd15;
   localparam logic [5:0] LAST_IDX = 6'd63;

   typedef struct packed {
      logic              is_dc;
      logic [3:0]        run;
      logic [SIZE_W-1:0] size;
      logic [VLI_W-1:0]  vli;
   } sym_t;

   typedef enum logic [2:0] {
      S_DC,
      S_AC,
      S_ZERO,
      S_VAL,
      S_FILL
   } state_t;

   function automatic logic is_eob(sym_t s);
      return !s.is_dc && (s.run == 4'd0) && (s.size == '0);
   endfunction

   function automatic logic is_zrl(sym_t s);
      return !s.is_dc && (s.run == ZRL_RUN) && (s.size == '0);
   endfunction

endpackage

// File: rtl/coef_run_expander_if.sv
// Symbol-in / coefficient-out handshake bundle.
// master = Huffman-decoder side plus downstream ready, slave = expander.
interface coef_run_expander_if #(
   parameter int DATA_WIDTH = 10
);
   localparam int SW = $clog2(DATA_WIDTH - 1) + 1;

   logic                  sym_valid;
   logic                  sym_ready;
   logic                  sym_isDC;
   logic [3:0]            sym_run;
   logic [SW-1:0]         sym_size;
   logic [DATA_WIDTH-2:0] sym_vli;
   logic                  pred_clr;
   logic                  coef_valid;
   logic                  coef_ready;
   logic [DATA_WIDTH-1:0] coef_data;
   logic                  coef_done;
   logic                  err;

   modport master (
      output sym_valid, sym_isDC, sym_run, sym_size, sym_vli,
      output pred_clr, coef_ready,
      input  sym_ready, coef_valid, coef_data, coef_done, err
   );

   modport slave (
      input  sym_valid, sym_isDC, sym_run, sym_size, sym_vli,
      input  pred_clr, coef_ready,
      output sym_ready, coef_valid, coef_data, coef_done, err
   );

endinterface

// File: rtl/coef_run_expander_vli_decode.sv
// Combinational VLI decode: low `size` bits of vli to a signed value.
// Sizes beyond the vli width are clamped to the full vli width.
module vli_decode #(
   parameter  int DATA_WIDTH = 10,
   localparam int VW = DATA_WIDTH - 1,
   localparam int SW = $clog2(VW) + 1
) (
   input  logic [VW-1:0]         vli,
   input  logic [SW-1:0]         size,
   output logic [DATA_WIDTH-1:0] value
);

   int                    sz;
   logic [VW-1:0]         m;
   logic                  msb;
   logic [DATA_WIDTH-1:0] ext;
   logic [DATA_WIDTH-1:0] span;

   always_comb begin
      sz  = (int'(size) > VW) ? VW : int'(size);
      m   = '0;
      msb = 1'b0;
      for (int i = 0; i < VW; i++) begin
         if (i < sz) m[i] = vli[i];
         if (i == sz - 1) msb = vli[i];
      end
      ext  = {1'b0, m};
      span = DATA_WIDTH'(1) << sz;
      if (sz == 0)
         value = '0;
      else if (msb)
         value = ext;
      else
         value = ext - span + DATA_WIDTH'(1);
   end

endmodule

// File: rtl/coef_run_expander.sv
// Expands (isDC, run, size, vli) symbols into 64 zigzag coefficients
// per block, with DC prediction and a registered output stage.
module coef_run_expander
   import coef_run_expander_pkg::*;
#(
   parameter int DATA_WIDTH = DW
) (
   input logic                clk,
   input logic                rst_n,
   coef_run_expander_if.slave bus
);

   state_t                state_q, state_d;
   logic [5:0]            idx_q, idx_d;
   logic [4:0]            zcnt_q, zcnt_d;
   logic                  zrl_q, zrl_d;
   logic [DATA_WIDTH-1:0] val_q, val_d;
   logic [DATA_WIDTH-1:0] pred_q, pred_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  live_q, live_d;

   logic                  adv;
   logic                  rdy;
   logic                  emit;
   logic [DATA_WIDTH-1:0] emit_val;
   logic [DATA_WIDTH-1:0] dec_val;
   sym_t                  sym;

   assign sym = '{
      is_dc: bus.sym_isDC,
      run:   bus.sym_run,
      size:  bus.sym_size,
      vli:   bus.sym_vli
   };

   vli_decode #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_vli (
      .vli  (sym.vli),
      .size (sym.size),
      .value(dec_val)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      zcnt_d   = zcnt_q;
      zrl_d    = zrl_q;
      val_d    = val_q;
      pred_d   = pred_q;
      data_d   = data_q;
      valid_d  = valid_q;
      done_d   = done_q;
      err_d    = 1'b0;
      live_d   = 1'b1;
      adv      = !valid_q || bus.coef_ready;
      rdy      = 1'b0;
      emit     = 1'b0;
      emit_val = '0;

      unique case (state_q)
         S_DC: begin
            rdy = live_q && adv;
            if (rdy && bus.sym_valid) begin
               if (sym.is_dc) begin
                  emit     = 1'b1;
                  emit_val = pred_q + dec_val;
                  pred_d   = emit_val;
                  state_d  = S_AC;
               end else if (!is_eob(sym)) begin
                  err_d = 1'b1;
               end
            end
         end
         S_AC: begin
            rdy = adv && !sym.is_dc;
            // A DC here means the block was cut short; pad it, then retake the DC
            if (bus.sym_valid && sym.is_dc) begin
               err_d   = 1'b1;
               state_d = S_FILL;
            end else if (rdy && bus.sym_valid) begin
               if (is_eob(sym)) begin
                  state_d = S_FILL;
               end else if (is_zrl(sym)) begin
                  zcnt_d  = 5'd16;
                  zrl_d   = 1'b1;
                  state_d = S_ZERO;
               end else begin
                  zcnt_d  = {1'b0, sym.run};
                  zrl_d   = 1'b0;
                  val_d   = dec_val;
                  state_d = (sym.run != 4'd0) ? S_ZERO : S_VAL;
               end
            end
         end
         S_ZERO: begin
            if (adv) begin
               emit   = 1'b1;
               zcnt_d = zcnt_q - 5'd1;
               if (zcnt_q == 5'd1)
                  state_d = zrl_q ? S_AC : S_VAL;
            end
         end
         S_VAL: begin
            if (adv) begin
               emit     = 1'b1;
               emit_val = val_q;
               state_d  = S_AC;
            end
         end
         S_FILL: begin
            if (adv) emit = 1'b1;
         end
         default: state_d = S_DC;
      endcase

      if (emit) begin
         valid_d = 1'b1;
         data_d  = emit_val;
         done_d  = (idx_q == LAST_IDX);
         idx_d   = idx_q + 6'd1;
         if (idx_q == LAST_IDX) begin
            state_d = S_DC;
            idx_d   = '0;
            zcnt_d  = '0;
            zrl_d   = 1'b0;
            // Zeros or a value still pending past the last slot are dropped
            if (state_q == S_ZERO && !(zrl_q && zcnt_q == 5'd1))
               err_d = 1'b1;
         end
      end else if (adv) begin
         valid_d = 1'b0;
         done_d  = 1'b0;
      end

      if (bus.pred_clr) pred_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_DC;
         idx_q   <= '0;
         zcnt_q  <= '0;
         zrl_q   <= 1'b0;
         val_q   <= '0;
         pred_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         zcnt_q  <= zcnt_d;
         zrl_q   <= zrl_d;
         val_q   <= val_d;
         pred_q  <= pred_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         err_q   <= err_d;
         live_q  <= live_d;
      end
   end

   assign bus.sym_ready  = rdy;
   assign bus.coef_valid = valid_q;
   assign bus.coef_data  = data_q;
   assign bus.coef_done  = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_coef_run_expander.sv
// Scoreboard bench for coef_run_expander: table-driven DC/AC vectors
// plus hand sequences for stalls, overflow, mid-block DC and reset.
module tb_coef_run_expander;

   localparam int W = 10;

   typedef struct packed {
      logic [W-1:0] data;
      logic         done;
   } exp_t;

   typedef struct packed {
      logic         clr;
      logic [4:0]   size;
      logic [8:0]   vli;
      logic [W-1:0] diff;
   } dc_vec_t;

   typedef struct packed {
      logic [3:0]   run;
      logic [4:0]   size;
      logic [8:0]   vli;
      logic [W-1:0] val;
   } ac_vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   coef_run_expander_if #(.DATA_WIDTH(W)) bus ();

   coef_run_expander #(.DATA_WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   exp_t         sb[$];
   exp_t         e;
   int           n_tests = 0;
   int           n_fail  = 0;
   int           rcv_cnt = 0;
   int           err_cnt = 0;
   int           rmode   = 0;
   logic         stall_prev = 1'b0;
   logic [W-1:0] stall_data = '0;
   logic [W-1:0] pred_m;
   logic [W-1:0] blk[64];
   dc_vec_t      dcv[9];
   ac_vec_t      acv[3];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_prev)
            check("stall_hold", 32'(bus.coef_data), 32'(stall_data));
         if (bus.err) err_cnt++;
         if (bus.coef_valid && bus.coef_ready) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_coef: got %0h, want none", bus.coef_data);
            end else begin
               e = sb.pop_front();
               check("coef_data", 32'(bus.coef_data), 32'(e.data));
               check("coef_done", 32'(bus.coef_done), 32'(e.done));
            end
            rcv_cnt++;
         end
         stall_prev = bus.coef_valid && !bus.coef_ready;
         stall_data = bus.coef_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      bus.coef_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            1:       bus.coef_ready = ~bus.coef_ready;
            2:       bus.coef_ready = 1'($urandom_range(0, 1));
            default: bus.coef_ready = 1'b1;
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got hang, want finish");
      $fatal(1, "timeout");
   end

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic send(input logic dc, input logic [3:0] run,
                       input logic [4:0] size, input logic [8:0] vli);
      int k = 0;
      bus.sym_valid = 1'b1;
      bus.sym_isDC  = dc;
      bus.sym_run   = run;
      bus.sym_size  = size;
      bus.sym_vli   = vli;
      forever begin
         @(negedge clk);
         if (bus.sym_ready) break;
         k++;
         if (k > 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL sym_accept: got no ready, want accept");
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.sym_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (k < 1000 && (sb.size() != 0 || bus.coef_valid)) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic clr_blk();
      for (int i = 0; i < 64; i++) blk[i] = '0;
   endtask

   task automatic push_blk();
      for (int i = 0; i < 64; i++) sb.push_back('{blk[i], i == 63});
      clr_blk();
   endtask

   task automatic clr_pred();
      bus.pred_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.pred_clr = 1'b0;
   endtask

   initial begin
      int e0;
      int pos;
      int r0;
      int r1;
      dcv[0] = '{1'b0, 5'd3, 9'b101,       10'd5};
      dcv[1] = '{1'b0, 5'd2, 9'b00,        10'h3FD};
      dcv[2] = '{1'b1, 5'd1, 9'b1,         10'd1};
      dcv[3] = '{1'b0, 5'd9, 9'h000,       10'h201};
      dcv[4] = '{1'b0, 5'd9, 9'h1FF,       10'd511};
      dcv[5] = '{1'b0, 5'd4, 9'b0111,      10'h3F8};
      dcv[6] = '{1'b0, 5'd5, 9'b111101010, 10'h3EB};
      dcv[7] = '{1'b0, 5'd0, 9'h1FF,       10'd0};
      dcv[8] = '{1'b0, 5'd9, 9'h000,       10'h201};
      acv[0] = '{4'd2,  5'd1, 9'b0,    10'h3FF};
      acv[1] = '{4'd15, 5'd0, 9'b0,    10'd0};
      acv[2] = '{4'd0,  5'd4, 9'b1000, 10'd8};

      bus.sym_valid = 1'b0;
      bus.sym_isDC  = 1'b0;
      bus.sym_run   = '0;
      bus.sym_size  = '0;
      bus.sym_vli   = '0;
      bus.pred_clr  = 1'b0;
      pred_m = '0;
      clr_blk();

      #12;
      check("rst_valid", 32'(bus.coef_valid), 32'd0);
      check("rst_data",  32'(bus.coef_data),  32'd0);
      check("rst_done",  32'(bus.coef_done),  32'd0);
      check("rst_err",   32'(bus.err),        32'd0);
      check("rst_ready", 32'(bus.sym_ready),  32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      e0 = err_cnt;
      for (int i = 0; i < 9; i++) begin
         if (dcv[i].clr) begin
            clr_pred();
            pred_m = '0;
         end
         pred_m = pred_m + dcv[i].diff;
         blk[0] = pred_m;
         push_blk();
         send(1'b1, 4'd0, dcv[i].size, dcv[i].vli);
         send(1'b0, 4'd0, 5'd0, 9'd0);
         drain();
      end
      check("dc_err", 32'(err_cnt - e0), 32'd0);

      blk[0] = pred_m;
      pos = 1;
      for (int i = 0; i < 3; i++) begin
         if (acv[i].run == 4'd15 && acv[i].size == 5'd0) begin
            pos += 16;
         end else begin
            pos += int'(acv[i].run);
            blk[pos] = acv[i].val;
            pos++;
         end
      end
      push_blk();
      send(1'b1, 4'd0, 5'd0, 9'd0);
      for (int i = 0; i < 3; i++)
         send(1'b0, acv[i].run, acv[i].size, acv[i].vli);
      send(1'b0, 4'd0, 5'd0, 9'd0);
      drain();

      rmode = 1;
      blk[0] = pred_m;
      blk[1] = 10'd1;
      blk[18] = 10'd3;
      push_blk();
      send(1'b1, 4'd0, 5'd0, 9'd0);
      send(1'b0, 4'd0, 5'd1, 9'd1);
      send(1'b0, 4'd15, 5'd0, 9'd0);
      r0 = rcv_cnt;
      send(1'b0, 4'd0, 5'd2, 9'b11);
      r1 = rcv_cnt;
      check("zrl_ready_low", 32'(r1 - r0 >= 15), 32'd1);
      send(1'b0, 4'd0, 5'd0, 9'd0);
      drain();

      rmode = 2;
      e0 = err_cnt;
      blk[0] = pred_m;
      for (int i = 1; i < 64; i++) blk[i] = (i % 2 == 1) ? 10'd1 : 10'h3FF;
      push_blk();
      send(1'b1, 4'd0, 5'd0, 9'd0);
      for (int i = 1; i < 64; i++)
         send(1'b0, 4'd0, 5'd1, (i % 2 == 1) ? 9'd1 : 9'd0);
      send(1'b0, 4'd0, 5'd0, 9'd0);
      pred_m = pred_m + 10'h3FC;
      blk[0] = pred_m;
      push_blk();
      send(1'b1, 4'd0, 5'd3, 9'b011);
      send(1'b0, 4'd0, 5'd0, 9'd0);
      drain();
      check("full_blk_err", 32'(err_cnt - e0), 32'd0);

      rmode = 0;
      e0 = err_cnt;
      blk[0] = pred_m;
      blk[59] = 10'd1;
      push_blk();
      send(1'b1, 4'd0, 5'd0, 9'd0);
      for (int i = 0; i < 3; i++) send(1'b0, 4'd15, 5'd0, 9'd0);
      send(1'b0, 4'd10, 5'd1, 9'd1);
      send(1'b0, 4'd15, 5'd1, 9'd1);
      drain();
      check("ovf_err", 32'(err_cnt - e0), 32'd1);

      e0 = err_cnt;
      blk[0] = pred_m;
      blk[1] = 10'd2;
      push_blk();
      pred_m = pred_m + 10'd1;
      blk[0] = pred_m;
      push_blk();
      send(1'b1, 4'd0, 5'd0, 9'd0);
      send(1'b0, 4'd0, 5'd2, 9'b10);
      send(1'b1, 4'd0, 5'd1, 9'd1);
      send(1'b0, 4'd0, 5'd0, 9'd0);
      drain();
      check("mid_dc_err", 32'(err_cnt - e0), 32'd1);

      blk[0] = pred_m + 10'd5;
      push_blk();
      send(1'b1, 4'd0, 5'd3, 9'b101);
      send(1'b0, 4'd0, 5'd0, 9'd0);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.coef_valid), 32'd0);
      check("mid_rst_data",  32'(bus.coef_data),  32'd0);
      check("mid_rst_done",  32'(bus.coef_done),  32'd0);
      check("mid_rst_ready", 32'(bus.sym_ready),  32'd0);
      sb.delete();
      pred_m = '0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      blk[0] = 10'd1;
      push_blk();
      send(1'b1, 4'd0, 5'd1, 9'd1);
      send(1'b0, 4'd0, 5'd0, 9'd0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/coef_run_expander.md
Name: coef_run_expander

Overview:
- Decode-side inverse of the entropy coder's symbol stage.
- Accepts (isDC, run, size, vli) symbols, including ZRL and EOB, and expands them into 64 coefficients per 8x8 block in zigzag order.
- DC prediction: adds each DC difference to a running predictor.
- Sits between the Huffman decoder and the de-zigzag/IDCT stage.

Parameters:
DATA_WIDTH, 10, coefficient width in bits, two's complement; vli is DATA_WIDTH-1 bits; size is $clog2(DATA_WIDTH-1)+1 bits.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
sym_valid  input  1  symbol present
sym_ready  output  1  symbol accepted when sym_valid && sym_ready
sym_isDC  input  1  symbol is a DC difference
sym_run  input  4  zero run preceding value (AC only)
sym_size  input  $clog2(DATA_WIDTH-1)+1  magnitude category
sym_vli  input  DATA_WIDTH-1  variable-length integer bits (low size bits significant)
pred_clr  input  1  synchronous clear of DC predictor (restart)
coef_valid  output  1  coefficient present
coef_ready  input  1  downstream accepts coefficient
coef_data  output  DATA_WIDTH  coefficient value
coef_done  output  1  qualifies coef_data as index 63 (last of block)
err  output  1  one-cycle protocol-error pulse

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: all outputs 0, state DC, idx 0, predictor 0.
- VLI decode:
  - m = vli masked to low size bits.
  - size==0 -> value 0.
  - m[size-1]==1 -> value = m, zero-extended.
  - Otherwise value = m - 2^size + 1, in DATA_WIDTH-bit two's complement.
- DC decode: coef = pred + value, mod 2^DATA_WIDTH; pred updated to coef on acceptance.
- pred_clr: zeroes pred; takes priority over a same-cycle DC update.
- Output register:
  - coef_data, coef_valid and coef_done are registered.
  - Coefficient appears the cycle after its symbol/step is taken.
  - Data stays stable while coef_valid && !coef_ready.
  - Throughput is one coefficient per cycle when coef_ready=1.
  - The register advances only when empty or being drained.
- idx: 6-bit count of coefficients emitted in the current block; coef_done=1 exactly when idx==63.
- State DC:
  - sym_ready = output can advance.
  - DC symbol: emit DC coef, idx=1, go to AC.
  - AC symbol with run=0 and size=0 (stray EOB after a full block): consumed silently.
  - Any other AC symbol: consumed, err pulse, no output.
- State AC:
  - sym_ready = output can advance.
  - EOB (run=0, size=0): go to FILL.
  - ZRL (run=15, size=0): load zcnt=16, go to ZERO.
  - Normal symbol: load zcnt=run, latch value; go to ZERO if run>0, else VAL.
  - DC symbol: not consumed (sym_ready=0), err pulse, go to FILL. The symbol is taken in DC state after the fill completes.
- State ZERO: sym_ready=0; emit 0 per advance and decrement zcnt. At zcnt reaching 0, go to VAL, or to AC if ZRL.
- State VAL: sym_ready=0; emit latched value, then go to AC.
- State FILL: sym_ready=0; emit zeros through idx 63.
- Block end: any emission at idx 63 sets coef_done, returns to DC and clears idx/zcnt.
- Overflow: if run or ZRL would pass idx 63, truncate at 63 (done there, pending value dropped) and pulse err.
- Reset mid-block: current block is discarded; pred returns to 0.

Decomposition:
- huffman_pkg: add a decode-side symbol struct mirroring the existing tempCode_t data fields.
- huffman_pkg: add localparams ZRL_RUN=15, LAST_IDX=63.
- Sub-module vli_decode (combinational; vli, size -> signed value) for separate unit testing.
- The state machine stays in this block.

Test Plan:
- DC size=3 vli=101b, then EOB -> coef 5 at idx0, then 63 zeros; coef_done on idx63; err=0.
- Second block: DC size=2 vli=00b (diff -3), then EOB -> first coef 2 (pred 5 + -3); pred_clr before third block: DC size=1 vli=1 -> coef 1.
- After DC: AC run=2 size=1 vli=0, then ZRL, then AC run=0 size=4 vli=1000b, then EOB -> idx1-2 = 0, idx3 = -1, idx4-19 = 0, idx20 = 8, remainder 0.
- coef_ready toggled 1010... during a ZRL -> coef_data stable while stalled; exactly 16 zeros; sym_ready low until ZRL done.
- Block of 63 nonzero ACs (no EOB), then EOB, then next DC -> done at idx63; stray EOB consumed silently; next block starts correctly.
- AC run=15 size=1 at idx60 -> zeros 60-63, done at 63, err pulse. DC symbol mid-block -> err, zero fill, DC then decoded. rst_n low mid-block -> outputs 0 the same cycle.
